// File: rtl/audio_pkg.sv
// ============================================================================
// Module : audio_pkg
// Brief  : Shared register offsets, sample constants and bus FSM states.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package audio_pkg;

  localparam logic [7:0] AUD_DATA   = 8'h00;
  localparam logic [7:0] AUD_STATUS = 8'h04;
  localparam logic [7:0] AUD_DIV    = 8'h08;
  localparam logic [7:0] AUD_CTRL   = 8'h0C;

  localparam int                    SAMPLE_W   = 12;
  localparam logic [SAMPLE_W-1:0]   SAMPLE_MID = 12'h800;

  typedef enum logic [0:0] {
    BUS_IDLE = 1'b0,
    BUS_ACK  = 1'b1
  } bus_state_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module : sync_fifo
// Brief  : Synchronous FIFO with flush; RAM read is registered (head prefetch).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_head;
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW-1:0]    w_rptr_nxt;
  logic [LW-1:0]    r_level;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push && !i_flush;
  assign w_pop  = i_pop  && !i_flush;

  always_comb begin
    w_rptr_nxt = r_rptr;
    if (i_flush)
      w_rptr_nxt = '0;
    else if (w_pop)
      w_rptr_nxt = r_rptr + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + 1'b1;
      if (w_pop)
        r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Head is prefetched from the next read pointer; write-first bypass covers a
  // push into the slot that becomes the head on the same edge.
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wptr] <= i_wdata;
    r_head <= (w_push && (r_wptr == w_rptr_nxt)) ? i_wdata : r_mem[w_rptr_nxt];
  end

  assign o_head  = r_head;
  assign o_level = r_level;
  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);

endmodule

`default_nettype wire

// File: rtl/audio_sample_streamer.sv
// ============================================================================
// Module : audio_sample_streamer
// Brief  : iomem audio peripheral; sample FIFO drained by a programmable tick.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module audio_sample_streamer
  import audio_pkg::*;
#(
  parameter int DEPTH    = 64,
  parameter int DIV_W    = 16,
  parameter int DIV_INIT = 2000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sel,
  output logic                ready,
  input  logic [3:0]          wstrb,
  input  logic [7:0]          addr,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                irq
);

  localparam int LW = $clog2(DEPTH) + 1;

  bus_state_t          r_state;
  bus_state_t          w_state_nxt;
  logic                w_acc;
  logic                w_wr;
  logic                w_rd;
  logic                w_data_wr;
  logic                w_div_wr;
  logic                w_ctrl_wr;
  logic                w_flush;
  logic                w_clr_un;
  logic                w_clr_ov;
  logic                w_tick;
  logic                w_pop;
  logic                w_push_ok;
  logic [31:0]         w_rd_data;
  logic [SAMPLE_W-1:0] w_head;
  logic [LW-1:0]       w_level;
  logic                w_full;
  logic                w_empty;
  logic                w_unused;

  logic [31:0]         r_rdata;
  logic [SAMPLE_W-1:0] r_sample;
  logic                r_irq;
  logic [DIV_W-1:0]    r_div;
  logic [DIV_W-1:0]    r_cnt;
  logic                r_enable;
  logic [7:0]          r_thresh;
  logic                r_underrun;
  logic                r_overflow;

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= BUS_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc       = 1'b0;
    case (r_state)
      BUS_IDLE: begin
        if (sel && !reset) begin
          w_acc       = 1'b1;
          w_state_nxt = BUS_ACK;
        end
      end
      BUS_ACK:  w_state_nxt = BUS_IDLE;
      default:  w_state_nxt = BUS_IDLE;
    endcase
  end

  assign w_wr      = w_acc && (|wstrb);
  assign w_rd      = w_acc && !(|wstrb);
  assign w_data_wr = w_wr && (addr == AUD_DATA);
  assign w_div_wr  = w_wr && (addr == AUD_DIV);
  assign w_ctrl_wr = w_wr && (addr == AUD_CTRL);
  assign w_flush   = w_ctrl_wr && wdata[1];
  assign w_clr_un  = w_ctrl_wr && wdata[2];
  assign w_clr_ov  = w_ctrl_wr && wdata[3];

  assign w_tick    = r_enable && (r_cnt == (r_div - 1'b1));
  assign w_pop     = w_tick && !w_empty && !w_flush;
  // A pop on the same edge frees a slot, so a full FIFO still accepts the push.
  assign w_push_ok = w_data_wr && (!w_full || w_pop);
  assign w_unused  = ^wdata[31:16];

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_push_ok),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_wdata (wdata[SAMPLE_W-1:0]),
    .o_head  (w_head),
    .o_level (w_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_rd_data = '0;
    case (addr)
      AUD_STATUS: w_rd_data = {12'h000, r_overflow, r_underrun, w_full, w_empty, 16'(w_level)};
      AUD_DIV:    w_rd_data = 32'(r_div);
      AUD_CTRL:   w_rd_data = {16'h0000, r_thresh, 7'h00, r_enable};
      default:    w_rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata    <= '0;
      r_sample   <= SAMPLE_MID;
      r_irq      <= 1'b0;
      r_div      <= DIV_W'(DIV_INIT);
      r_cnt      <= '0;
      r_enable   <= 1'b0;
      r_thresh   <= 8'(DEPTH / 4);
      r_underrun <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_rdata <= w_rd ? w_rd_data : '0;

      if (w_div_wr)
        r_div <= (wdata[DIV_W-1:0] == '0) ? DIV_W'(1) : wdata[DIV_W-1:0];

      if (w_ctrl_wr) begin
        r_enable <= wdata[0];
        r_thresh <= wdata[15:8];
      end

      if (w_div_wr || !r_enable || w_tick)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;

      if (w_pop)
        r_sample <= w_head;

      r_underrun <= (w_tick && w_empty) || (r_underrun && !w_clr_un);
      r_overflow <= (w_data_wr && !w_push_ok) || (r_overflow && !w_clr_ov);

      r_irq <= r_enable && (32'(w_level) <= 32'(r_thresh));
    end
  end

  assign ready      = (r_state == BUS_ACK);
  assign rdata      = r_rdata;
  assign sample_out = r_sample;
  assign irq        = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_audio_sample_streamer.sv
// ============================================================================
// Module : tb_audio_sample_streamer
// Brief  : Directed self-checking bench for audio_sample_streamer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_audio_sample_streamer;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        ready;
  logic [3:0]  wstrb;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [11:0] sample_out;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;

  audio_sample_streamer #(
    .DEPTH    (64),
    .DIV_W    (16),
    .DIV_INIT (2000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sel        (sel),
    .ready      (ready),
    .wstrb      (wstrb),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .sample_out (sample_out),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Access edge is the first posedge; returns #1 after the ready cycle ends.
  task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
    sel = 1'b1; addr = a; wdata = d; wstrb = 4'hF;
    @(posedge clk); #1;
    sel = 1'b0; wstrb = 4'h0;
    @(posedge clk); #1;
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [31:0] d);
    sel = 1'b1; addr = a; wstrb = 4'h0;
    @(posedge clk); #1;
    d = rdata; sel = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", ready); end
    n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL rst_rdata: got %h want 0", rdata); end
    n_cmp++; if (sample_out !== 12'h800) begin n_err++; $display("FAIL rst_sample: got %h want 800", sample_out); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL rst_irq: got %b want 0", irq); end
    reset = 1'b0;
    @(posedge clk); #1;
    sel = 1'b1; addr = 8'h04; wstrb = 4'h0;
    @(posedge clk); #1;
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL rst_ack_ready: got %b want 1", ready); end
    n_cmp++; if (rdata !== 32'h0001_0000) begin n_err++; $display("FAIL rst_status: got %h want 00010000", rdata); end
    sel = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL rst_ack_drop: got %b want 0", ready); end
    bus_rd(8'h08, d);
    n_cmp++; if (d !== 32'd2000) begin n_err++; $display("FAIL rst_div: got %h want %h", d, 32'd2000); end
    bus_rd(8'h0C, d);
    n_cmp++; if (d !== 32'h0000_1000) begin n_err++; $display("FAIL rst_ctrl: got %h want 00001000", d); end
  endtask

  task automatic test_regs();
    logic [31:0] d;
    bus_wr(8'h08, 32'h0);
    bus_rd(8'h08, d);
    n_cmp++; if (d !== 32'h1) begin n_err++; $display("FAIL div_zero: got %h want 1", d); end
    bus_wr(8'h10, 32'hFFFF_FFFF);
    bus_rd(8'h10, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL unmapped_rd: got %h want 0", d); end
    bus_rd(8'h00, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL data_rd: got %h want 0", d); end
    bus_wr(8'h0C, 32'h0000_2A0E);
    bus_rd(8'h0C, d);
    n_cmp++; if (d !== 32'h0000_2A00) begin n_err++; $display("FAIL ctrl_rw: got %h want 00002a00", d); end
    bus_rd(8'h04, d);
    n_cmp++; if (d !== 32'h0001_0000) begin n_err++; $display("FAIL regs_status: got %h want 00010000", d); end
  endtask

  task automatic test_playback();
    logic [31:0] d;
    bus_wr(8'h08, 32'd4);
    bus_wr(8'h00, 32'h100);
    bus_wr(8'h00, 32'h200);
    bus_wr(8'h00, 32'h300);
    bus_wr(8'h0C, 32'h1);
    @(posedge clk); @(posedge clk); #1;
    n_cmp++; if (sample_out !== 12'h800) begin n_err++; $display("FAIL play_pre: got %h want 800", sample_out); end
    @(posedge clk); #1;
    n_cmp++; if (sample_out !== 12'h100) begin n_err++; $display("FAIL play_t1: got %h want 100", sample_out); end
    repeat (4) @(posedge clk); #1;
    n_cmp++; if (sample_out !== 12'h200) begin n_err++; $display("FAIL play_t2: got %h want 200", sample_out); end
    repeat (4) @(posedge clk); #1;
    n_cmp++; if (sample_out !== 12'h300) begin n_err++; $display("FAIL play_t3: got %h want 300", sample_out); end
    repeat (4) @(posedge clk); #1;
    n_cmp++; if (sample_out !== 12'h300) begin n_err++; $display("FAIL play_t4: got %h want 300", sample_out); end
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL play_irq: got %b want 1", irq); end
    bus_rd(8'h04, d);
    n_cmp++; if (d !== 32'h0005_0000) begin n_err++; $display("FAIL play_underrun: got %h want 00050000", d); end
    bus_wr(8'h0C, 32'h0);
    bus_wr(8'h0C, 32'h4);
    bus_rd(8'h04, d);
    n_cmp++; if (d !== 32'h0001_0000) begin n_err++; $display("FAIL play_clr_un: got %h want 00010000", d); end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    for (int i = 0; i < 64; i++)
      bus_wr(8'h00, 32'h400 + 32'(i));
    bus_rd(8'h04, d);
    n_cmp++; if (d !== 32'h0002_0040) begin n_err++; $display("FAIL ovf_full: got %h want 00020040", d); end
    bus_wr(8'h00, 32'hFFF);
    bus_rd(8'h04, d);
    n_cmp++; if (d !== 32'h000A_0040) begin n_err++; $display("FAIL ovf_set: got %h want 000a0040", d); end
    bus_wr(8'h0C, 32'h8);
    bus_rd(8'h04, d);
    n_cmp++; if (d !== 32'h0002_0040) begin n_err++; $display("FAIL ovf_clr: got %h want 00020040", d); end
  endtask

  // Full FIFO: the DATA access edge is placed on the first tick (DIV=3).
  task automatic test_push_on_tick();
    logic [31:0] d;
    bus_wr(8'h08, 32'd3);
    bus_wr(8'h0C, 32'h1);
    @(posedge clk); #1;
    bus_wr(8'h00, 32'hABC);
    bus_wr(8'h0C, 32'h0);
    n_cmp++; if (sample_out !== 12'h400) begin n_err++; $display("FAIL pot_sample: got %h want 400", sample_out); end
    bus_rd(8'h04, d);
    n_cmp++; if (d !== 32'h0002_0040) begin n_err++; $display("FAIL pot_status: got %h want 00020040", d); end
  endtask

  task automatic test_irq_flush();
    logic [31:0] d;
    bus_wr(8'h0C, 32'h0000_0202);
    bus_wr(8'h00, 32'h111);
    bus_wr(8'h00, 32'h222);
    bus_wr(8'h00, 32'h333);
    bus_wr(8'h08, 32'd3);
    bus_wr(8'h0C, 32'h0000_0201);
    @(posedge clk); @(posedge clk); #1;
    n_cmp++; if (sample_out !== 12'h111) begin n_err++; $display("FAIL irq_pop: got %h want 111", sample_out); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_early: got %b want 0", irq); end
    @(posedge clk); #1;
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_set: got %b want 1", irq); end
    bus_wr(8'h0C, 32'h0000_0202);
    n_cmp++; if (sample_out !== 12'h111) begin n_err++; $display("FAIL flush_hold: got %h want 111", sample_out); end
    bus_rd(8'h04, d);
    n_cmp++; if (d !== 32'h0001_0000) begin n_err++; $display("FAIL flush_status: got %h want 00010000", d); end
  endtask

  task automatic test_reset_midxfer();
    logic [31:0] d;
    for (int i = 0; i < 10; i++)
      bus_wr(8'h00, 32'h500 + 32'(i));
    bus_wr(8'h08, 32'd7);
    sel = 1'b1; addr = 8'h00; wdata = 32'h5FF; wstrb = 4'hF;
    @(posedge clk); #1;
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL mid_ready_hi: got %b want 1", ready); end
    reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL mid_ready_lo: got %b want 0", ready); end
    n_cmp++; if (sample_out !== 12'h800) begin n_err++; $display("FAIL mid_sample: got %h want 800", sample_out); end
    @(posedge clk); #1;
    n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL mid_ready_rst: got %b want 0", ready); end
    sel = 1'b0; wstrb = 4'h0; reset = 1'b0;
    @(posedge clk); #1;
    bus_rd(8'h04, d);
    n_cmp++; if (d !== 32'h0001_0000) begin n_err++; $display("FAIL mid_status: got %h want 00010000", d); end
    bus_rd(8'h08, d);
    n_cmp++; if (d !== 32'd2000) begin n_err++; $display("FAIL mid_div: got %h want %h", d, 32'd2000); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL mid_irq: got %b want 0", irq); end
  endtask

  initial begin
    reset = 1'b1; sel = 1'b0; wstrb = 4'h0; addr = 8'h00; wdata = 32'h0;
    repeat (3) @(posedge clk); #1;
    test_reset();
    test_regs();
    test_playback();
    test_overflow();
    test_push_on_tick();
    test_irq_flush();
    test_reset_midxfer();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
